setn_pulse_gen: RTL and testbench

//   Generates the active-low SETN for a bank of async-set flops (dffsnq family) from a

---
 rtl/setn_pulse_gen.sv | 103 ++++++++++
 tb/tb_setn_pulse_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/setn_pulse_gen.sv
// Active-low SETN pulse generator for async-set flop banks: guaranteed minimum low width,
// a recovery hold-off, then DONE/READY, with a one-deep pending request slot.
module setn_pulse_gen #(
    parameter int MIN_LOW_CYC  = 2,
    parameter int RECOVERY_CYC = 1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_req,
    input  logic [CNT_W-1:0] set_len,
    output logic             setn,
    output logic             ready,
    output logic             done,
    output logic             drop
);

    typedef enum logic [1:0] {IDLE, LOW, RECOVER} state_t;

    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_LOW_CYC);
    localparam logic [CNT_W-1:0] REC_LEN = CNT_W'(RECOVERY_CYC);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pend, pend_n;
    logic [CNT_W-1:0] pend_len, pend_len_n;
    logic             done_n, drop_n;
    logic [CNT_W-1:0] req_len;

    assign req_len = (set_len < MIN_LEN) ? MIN_LEN : set_len;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pend_n     = pend;
        pend_len_n = pend_len;
        done_n     = 1'b0;
        drop_n     = 1'b0;
        case (state)
            IDLE: begin
                // A held request wins; a same-cycle new request backfills the slot.
                if (pend) begin
                    state_n = LOW;
                    cnt_n   = pend_len;
                    pend_n  = set_req;
                    if (set_req) pend_len_n = req_len;
                end else if (set_req) begin
                    state_n = LOW;
                    cnt_n   = req_len;
                end
            end
            LOW: begin
                if (cnt == CNT_W'(1)) begin
                    state_n = RECOVER;
                    cnt_n   = REC_LEN;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            RECOVER: begin
                if (cnt == CNT_W'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        if (state != IDLE && set_req) begin
            if (pend) begin
                drop_n = 1'b1;
            end else begin
                pend_n     = 1'b1;
                pend_len_n = req_len;
            end
        end
    end

    // All outputs come straight from flops; setn/ready are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pend     <= 1'b0;
            pend_len <= '0;
            setn     <= 1'b1;
            ready    <= 1'b1;
            done     <= 1'b0;
            drop     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pend     <= pend_n;
            pend_len <= pend_len_n;
            setn     <= (state_n != LOW);
            ready    <= (state_n == IDLE);
            done     <= done_n;
            drop     <= drop_n;
        end
    end

endmodule

// File: tb/tb_setn_pulse_gen.sv
// Bench for setn_pulse_gen: vector table, directed multi-cycle sequences and random
// stimulus against a schedule-based reference model.
module tb_setn_pulse_gen;

    localparam int MIN_LOW_CYC  = 2;
    localparam int RECOVERY_CYC = 1;
    localparam int CNT_W        = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             set_req = 1'b0;
    logic [CNT_W-1:0] set_len = '0;
    logic             setn, ready, done, drop;

    setn_pulse_gen #(
        .MIN_LOW_CYC (MIN_LOW_CYC),
        .RECOVERY_CYC(RECOVERY_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .set_req(set_req),
        .set_len(set_len),
        .setn   (setn),
        .ready  (ready),
        .done   (done),
        .drop   (drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    // Reference model: each accepted request is a window [s, s+L+R] in edge numbers.
    int t = 0;
    bit active = 0;
    int s = 0, L = 0;
    int pq[$];
    bit m_setn, m_ready, m_done, m_drop;

    task automatic model_edge(input bit r, input bit q, input int l);
        int len;
        bit idle;
        len = (l < MIN_LOW_CYC) ? MIN_LOW_CYC : l;
        t++;
        m_drop = 0;
        if (r) begin
            active = 0;
            pq.delete();
        end else begin
            idle = !active || (t >= s + L + RECOVERY_CYC + 1);
            if (idle) begin
                if (pq.size() > 0) begin
                    L = pq.pop_front(); s = t; active = 1;
                    if (q) pq.push_back(len);
                end else if (q) begin
                    L = len; s = t; active = 1;
                end
            end else if (q) begin
                if (pq.size() > 0) m_drop = 1;
                else pq.push_back(len);
            end
        end
        m_setn  = !(active && t >= s && t <= s + L - 1);
        m_ready = !(active && t >= s && t <= s + L + RECOVERY_CYC - 1);
        m_done  = active && (t == s + L + RECOVERY_CYC);
    endtask

    bit hist_setn[$];
    int n_done = 0, n_drop = 0;

    task automatic step(input bit r, input bit q, input int l);
        rst = r; set_req = q; set_len = CNT_W'(l);
        @(posedge clk);
        model_edge(r, q, l);
        #1;
        chk("model_setn",  int'(setn),  int'(m_setn));
        chk("model_ready", int'(ready), int'(m_ready));
        chk("model_done",  int'(done),  int'(m_done));
        chk("model_drop",  int'(drop),  int'(m_drop));
        hist_setn.push_back(setn);
        n_done += int'(done);
        n_drop += int'(drop);
    endtask

    task automatic clear_hist();
        hist_setn.delete(); n_done = 0; n_drop = 0;
    endtask

    // Low-pulse widths and high gaps between pulses from the recorded SETN history.
    int widths[$];
    int gaps[$];
    task automatic analyse();
        int run;
        bit seen_low;
        widths.delete(); gaps.delete();
        run = 0; seen_low = 0;
        for (int i = 0; i < hist_setn.size(); i++) begin
            if (i > 0 && hist_setn[i] != hist_setn[i-1]) begin
                if (!hist_setn[i-1]) widths.push_back(run);
                else if (seen_low) gaps.push_back(run);
                run = 0;
            end
            if (!hist_setn[i]) seen_low = 1;
            run++;
        end
        if (hist_setn.size() > 0 && !hist_setn[hist_setn.size()-1]) widths.push_back(run);
    endtask

    typedef struct {
        bit r, q; int l;
        bit e_setn, e_ready, e_done, e_drop;
    } vec_t;

    initial begin
        vec_t vt[$];
        // reset with request held, then len 5, len 0, len 1
        vt.push_back('{1,1,5, 1,1,0,0});
        vt.push_back('{1,1,5, 1,1,0,0});
        vt.push_back('{0,1,5, 0,0,0,0});
        vt.push_back('{0,0,0, 0,0,0,0});
        vt.push_back('{0,0,0, 0,0,0,0});
        vt.push_back('{0,0,0, 0,0,0,0});
        vt.push_back('{0,0,0, 0,0,0,0});
        vt.push_back('{0,0,0, 1,0,0,0});
        vt.push_back('{0,0,0, 1,1,1,0});
        vt.push_back('{0,0,0, 1,1,0,0});
        vt.push_back('{0,1,0, 0,0,0,0});
        vt.push_back('{0,0,0, 0,0,0,0});
        vt.push_back('{0,0,0, 1,0,0,0});
        vt.push_back('{0,0,0, 1,1,1,0});
        vt.push_back('{0,1,1, 0,0,0,0});
        vt.push_back('{0,0,0, 0,0,0,0});
        vt.push_back('{0,0,0, 1,0,0,0});
        vt.push_back('{0,0,0, 1,1,1,0});
        vt.push_back('{0,0,0, 1,1,0,0});

        @(negedge clk);
        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].r, vt[i].q, vt[i].l);
            chk($sformatf("vec%0d_setn", i),  int'(setn),  int'(vt[i].e_setn));
            chk($sformatf("vec%0d_ready", i), int'(ready), int'(vt[i].e_ready));
            chk($sformatf("vec%0d_done", i),  int'(done),  int'(vt[i].e_done));
            chk($sformatf("vec%0d_drop", i),  int'(drop),  int'(vt[i].e_drop));
        end

        // Queued request: len 4 then len 3 issued during the first pulse.
        clear_hist();
        step(0, 1, 4);
        step(0, 1, 3);
        for (int i = 0; i < 14; i++) step(0, 0, 0);
        analyse();
        chk("q_pulses", widths.size(), 2);
        if (widths.size() == 2) begin
            chk("q_w0", widths[0], 4);
            chk("q_w1", widths[1], 3);
        end
        chk("q_gaps", gaps.size(), 1);
        if (gaps.size() >= 1) chk("q_gap", gaps[0], 2);
        chk("q_dones", n_done, 2);
        chk("q_drops", n_drop, 0);

        // Third request while the slot is full is dropped.
        clear_hist();
        step(0, 1, 4);
        step(0, 1, 3);
        step(0, 1, 6);
        for (int i = 0; i < 14; i++) step(0, 0, 0);
        analyse();
        chk("d_pulses", widths.size(), 2);
        if (widths.size() == 2) chk("d_w1", widths[1], 3);
        chk("d_drops", n_drop, 1);
        chk("d_dones", n_done, 2);

        // Reset in the second cycle of a len-6 pulse, with a request pending.
        step(0, 1, 6);
        step(0, 1, 3);
        clear_hist();
        step(1, 0, 0);
        chk("r_setn", int'(setn), 1);
        chk("r_ready", int'(ready), 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        analyse();
        chk("r_pulses", widths.size(), 0);
        chk("r_dones", n_done, 0);
        chk("r_ready_after", int'(ready), 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 3), int'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
